// File: rtl/wb_burst_biu.sv
// wb_burst_biu: Wishbone B3 bus interface unit for the data cache.
// Turns a cache line request into an 8-beat incrementing burst (read or write)
// and a peripheral/uncached request into a single classic cycle.
// Build option: define WB_BURST_BIU_RTY_EN to reissue a beat after wb_rty_i;
// without it, wb_rty_i aborts the transaction like wb_err_i.
// Bus handshake: a beat is offered while wb_cyc_o & wb_stb_o are high and
// completes on the rising edge where the slave asserts wb_ack_i (or
// terminates with wb_err_i / wb_rty_i); request side is accepted in IDLE on
// biu_cyc_i & biu_stb_i & ~freeze and answered by a bus_rdy pulse.
module wb_burst_biu #(
    parameter int BEATS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  biu_cyc_i,
    input  logic                  biu_stb_i,
    input  logic                  biu_we_i,
    input  logic                  biu_cab_i,
    input  logic                  prp_acs,
    input  logic [31:0]           biu_adr_i,
    input  logic [3:0]            biu_sel_i,
    input  logic [32*BEATS-1:0]   bus_wdata_i,
    output logic [31:0]           biu_dat_o,
    output logic [32*BEATS-1:0]   bus_rdata_o,
    output logic                  bus_rdy,
    output logic                  biu_err_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic [31:0]           wb_dat_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o
);

`ifdef WB_BURST_BIU_RTY_EN
    localparam logic RTY_EN = 1'b1;
`else
    localparam logic RTY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 burst_q, burst_d;
    logic [32*BEATS-1:0]  line_q, line_d;
    logic [32*BEATS-1:0]  rdata_q, rdata_d;
    logic [31:0]          bdat_q, bdat_d;
    logic                 rdy_q, rdy_d;
    logic                 err_q, err_d;
    logic                 cyc_q, cyc_d;
    logic                 stb_q, stb_d;
    logic                 we_q, we_d;
    logic [31:0]          adr_q, adr_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          dat_q, dat_d;
    logic [2:0]           cti_q, cti_d;
    logic [1:0]           bte_q, bte_d;
    logic [2:0]           cnt_nx;

    // Next-state and registered-output computation for the IDLE/BUS/DONE machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        bdat_d  = bdat_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        cti_d   = cti_q;
        bte_d   = bte_q;
        cnt_nx  = cnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (biu_cyc_i && biu_stb_i && !freeze) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = biu_we_i;
                    cnt_d   = 3'd0;
                    burst_d = biu_cab_i && !prp_acs;
                    line_d  = bus_wdata_i;
                    dat_d   = bus_wdata_i[31:0];
                    bte_d   = 2'b00;
                    if (biu_cab_i && !prp_acs) begin
                        adr_d = {biu_adr_i[31:5], 5'b0};
                        sel_d = 4'hF;
                        cti_d = 3'b010;
                    end else begin
                        adr_d = biu_adr_i;
                        sel_d = biu_sel_i;
                        cti_d = 3'b000;
                    end
                end
            end
            BUS: begin
                if (!stb_q) begin
                    // Retry gap is over: reoffer the same beat.
                    stb_d = 1'b1;
                end else if (wb_err_i || (wb_rty_i && !RTY_EN)) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    cti_d   = 3'b000;
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rdata_d[{cnt_q, 5'b0} +: 32] = wb_dat_i;
                        bdat_d = wb_dat_i;
                    end
                    cnt_d = cnt_nx;
                    if (burst_q) begin
                        // Address wraps inside the line by construction of cnt.
                        adr_d = {adr_q[31:5], cnt_nx, 2'b00};
                        dat_d = line_q[{cnt_nx, 5'b0} +: 32];
                    end
                    if (!burst_q || cnt_q == 3'd7) begin
                        cyc_d   = 1'b0;
                        stb_d   = 1'b0;
                        cti_d   = 3'b000;
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        err_d   = 1'b0;
                    end else if (cnt_nx == 3'd7) begin
                        cti_d = 3'b111;
                    end
                end else if (wb_rty_i) begin
                    // Only reachable with retry enabled: drop stb for one cycle.
                    stb_d = 1'b0;
                end
            end
            DONE: begin
                if (!freeze) begin
                    state_d = IDLE;
                    rdy_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                rdy_d   = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            burst_q <= 1'b0;
            line_q  <= '0;
            rdata_q <= '0;
            bdat_q  <= 32'd0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
            cti_q   <= 3'd0;
            bte_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            bdat_q  <= bdat_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
        end
    end

    assign biu_dat_o   = bdat_q;
    assign bus_rdata_o = rdata_q;
    assign bus_rdy     = rdy_q;
    assign biu_err_o   = err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;
    assign wb_cti_o    = cti_q;
    assign wb_bte_o    = bte_q;

endmodule

// File: tb/tb_wb_burst_biu.sv
// Directed testbench for wb_burst_biu. Inputs change and outputs are sampled
// on the falling edge; the bench plays the Wishbone slave itself.
module tb_wb_burst_biu;

    logic         clk = 1'b0;
    logic         rst;
    logic         freeze;
    logic         biu_cyc_i, biu_stb_i, biu_we_i, biu_cab_i, prp_acs;
    logic [31:0]  biu_adr_i;
    logic [3:0]   biu_sel_i;
    logic [255:0] bus_wdata_i;
    logic [31:0]  biu_dat_o;
    logic [255:0] bus_rdata_o;
    logic         bus_rdy, biu_err_o;
    logic         wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0]  wb_dat_i;
    logic         wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]  wb_adr_o;
    logic [3:0]   wb_sel_o;
    logic [31:0]  wb_dat_o;
    logic [2:0]   wb_cti_o;
    logic [1:0]   wb_bte_o;

    int n_vec = 0;
    int n_err = 0;

    wb_burst_biu #(.BEATS(8)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .biu_cyc_i(biu_cyc_i), .biu_stb_i(biu_stb_i), .biu_we_i(biu_we_i),
        .biu_cab_i(biu_cab_i), .prp_acs(prp_acs), .biu_adr_i(biu_adr_i),
        .biu_sel_i(biu_sel_i), .bus_wdata_i(bus_wdata_i),
        .biu_dat_o(biu_dat_o), .bus_rdata_o(bus_rdata_o),
        .bus_rdy(bus_rdy), .biu_err_o(biu_err_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_dat_i(wb_dat_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
        .wb_dat_o(wb_dat_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a request for one cycle, then scramble the request inputs.
    task automatic issue(input logic we, input logic cab, input logic prp,
                         input logic [31:0] adr, input logic [3:0] sel);
        biu_cyc_i = 1'b1; biu_stb_i = 1'b1; biu_we_i = we; biu_cab_i = cab;
        prp_acs = prp; biu_adr_i = adr; biu_sel_i = sel;
        tick();
        biu_cyc_i = 1'b0; biu_stb_i = 1'b0; biu_adr_i = 32'hFFFF_FFFC;
        biu_sel_i = 4'hC; biu_we_i = ~we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL rst_cyc: got %b want 0", wb_cyc_o); end
        n_vec++; if (wb_stb_o !== 1'b0) begin n_err++; $display("FAIL rst_stb: got %b want 0", wb_stb_o); end
        n_vec++; if (wb_we_o !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", wb_we_o); end
        n_vec++; if (wb_adr_o !== 32'd0) begin n_err++; $display("FAIL rst_adr: got %h want 0", wb_adr_o); end
        n_vec++; if (wb_sel_o !== 4'd0) begin n_err++; $display("FAIL rst_sel: got %h want 0", wb_sel_o); end
        n_vec++; if (wb_dat_o !== 32'd0) begin n_err++; $display("FAIL rst_dat: got %h want 0", wb_dat_o); end
        n_vec++; if (wb_cti_o !== 3'd0) begin n_err++; $display("FAIL rst_cti: got %b want 0", wb_cti_o); end
        n_vec++; if (wb_bte_o !== 2'd0) begin n_err++; $display("FAIL rst_bte: got %b want 0", wb_bte_o); end
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b want 0", bus_rdy); end
        n_vec++; if (biu_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", biu_err_o); end
        n_vec++; if (biu_dat_o !== 32'd0) begin n_err++; $display("FAIL rst_bdat: got %h want 0", biu_dat_o); end
        n_vec++; if (bus_rdata_o !== 256'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", bus_rdata_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_burst();
        logic [2:0]  exp_cti;
        logic [31:0] exp_adr;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_1234, 4'h0);
        n_vec++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin n_err++; $display("FAIL rd_cycstb: got %b%b want 11", wb_cyc_o, wb_stb_o); end
        n_vec++; if (wb_we_o !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b want 0", wb_we_o); end
        n_vec++; if (wb_sel_o !== 4'hF) begin n_err++; $display("FAIL rd_sel: got %h want F", wb_sel_o); end
        n_vec++; if (wb_bte_o !== 2'b00) begin n_err++; $display("FAIL rd_bte: got %b want 00", wb_bte_o); end
        for (int k = 0; k < 8; k++) begin
            exp_adr = 32'h0000_1220 + 32'(4 * k);
            exp_cti = (k == 7) ? 3'b111 : 3'b010;
            n_vec++; if (wb_adr_o !== exp_adr) begin n_err++; $display("FAIL rd_adr[%0d]: got %h want %h", k, wb_adr_o, exp_adr); end
            n_vec++; if (wb_cti_o !== exp_cti) begin n_err++; $display("FAIL rd_cti[%0d]: got %b want %b", k, wb_cti_o, exp_cti); end
            n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL rd_rdy_early[%0d]: got %b want 0", k, bus_rdy); end
            wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + 32'(k);
            tick();
        end
        wb_ack_i = 1'b0;
        n_vec++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_err++; $display("FAIL rd_end_cycstb: got %b%b want 00", wb_cyc_o, wb_stb_o); end
        n_vec++; if (wb_cti_o !== 3'b000) begin n_err++; $display("FAIL rd_end_cti: got %b want 000", wb_cti_o); end
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL rd_rdy: got %b want 1", bus_rdy); end
        n_vec++; if (biu_err_o !== 1'b0) begin n_err++; $display("FAIL rd_err: got %b want 0", biu_err_o); end
        n_vec++; if (biu_dat_o !== 32'hA7) begin n_err++; $display("FAIL rd_bdat: got %h want a7", biu_dat_o); end
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (bus_rdata_o[32*k +: 32] !== 32'hA0 + 32'(k)) begin n_err++; $display("FAIL rd_word[%0d]: got %h want %h", k, bus_rdata_o[32*k +: 32], 32'hA0 + 32'(k)); end
        end
        tick();
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL rd_rdy_pulse: got %b want 0", bus_rdy); end
        n_vec++; if (biu_dat_o !== 32'hA7) begin n_err++; $display("FAIL rd_bdat_hold: got %h want a7", biu_dat_o); end
    endtask

    task automatic test_write_burst();
        logic [31:0] exp_dat;
        for (int k = 0; k < 8; k++) bus_wdata_i[32*k +: 32] = 32'h11 * 32'(k);
        issue(1'b1, 1'b1, 1'b0, 32'h0000_2000, 4'h0);
        bus_wdata_i = '1;
        for (int k = 0; k < 8; k++) begin
            exp_dat = 32'h11 * 32'(k);
            n_vec++; if (wb_we_o !== 1'b1) begin n_err++; $display("FAIL wr_we[%0d]: got %b want 1", k, wb_we_o); end
            n_vec++; if (wb_sel_o !== 4'hF) begin n_err++; $display("FAIL wr_sel[%0d]: got %h want F", k, wb_sel_o); end
            n_vec++; if (wb_adr_o !== 32'h2000 + 32'(4 * k)) begin n_err++; $display("FAIL wr_adr[%0d]: got %h want %h", k, wb_adr_o, 32'h2000 + 32'(4 * k)); end
            n_vec++; if (wb_dat_o !== exp_dat) begin n_err++; $display("FAIL wr_dat[%0d]: got %h want %h", k, wb_dat_o, exp_dat); end
            tick();
            n_vec++; if (wb_dat_o !== exp_dat) begin n_err++; $display("FAIL wr_dat_hold[%0d]: got %h want %h", k, wb_dat_o, exp_dat); end
            n_vec++; if (wb_cyc_o !== 1'b1 || bus_rdy !== 1'b0) begin n_err++; $display("FAIL wr_wait[%0d]: cyc/rdy got %b%b want 10", k, wb_cyc_o, bus_rdy); end
            wb_ack_i = 1'b1;
            tick();
            wb_ack_i = 1'b0;
        end
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL wr_rdy: got %b want 1", bus_rdy); end
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL wr_end_cyc: got %b want 0", wb_cyc_o); end
        tick();
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL wr_rdy_pulse: got %b want 0", bus_rdy); end
    endtask

    task automatic test_single_read();
        issue(1'b0, 1'b1, 1'b1, 32'h9000_0004, 4'b0011);
        n_vec++; if (wb_cyc_o !== 1'b1) begin n_err++; $display("FAIL sr_cyc: got %b want 1", wb_cyc_o); end
        n_vec++; if (wb_cti_o !== 3'b000) begin n_err++; $display("FAIL sr_cti: got %b want 000", wb_cti_o); end
        n_vec++; if (wb_sel_o !== 4'b0011) begin n_err++; $display("FAIL sr_sel: got %b want 0011", wb_sel_o); end
        n_vec++; if (wb_adr_o !== 32'h9000_0004) begin n_err++; $display("FAIL sr_adr: got %h want 90000004", wb_adr_o); end
        tick();
        n_vec++; if (wb_cyc_o !== 1'b1 || bus_rdy !== 1'b0) begin n_err++; $display("FAIL sr_wait: cyc/rdy got %b%b want 10", wb_cyc_o, bus_rdy); end
        wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
        tick();
        wb_ack_i = 1'b0;
        n_vec++; if (biu_dat_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL sr_bdat: got %h want deadbeef", biu_dat_o); end
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL sr_rdy: got %b want 1", bus_rdy); end
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL sr_end_cyc: got %b want 0", wb_cyc_o); end
        tick();
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL sr_rdy_pulse: got %b want 0", bus_rdy); end
    endtask

    task automatic test_error();
        logic [31:0] exp_w;
        issue(1'b0, 1'b1, 1'b0, 32'h0000_3000, 4'h0);
        for (int k = 0; k < 3; k++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'hB0 + 32'(k);
            tick();
        end
        n_vec++; if (wb_adr_o !== 32'h300C) begin n_err++; $display("FAIL er_adr3: got %h want 300c", wb_adr_o); end
        // ack and err together: err must win.
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFF;
        tick();
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        n_vec++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_err++; $display("FAIL er_cycstb: got %b%b want 00", wb_cyc_o, wb_stb_o); end
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL er_rdy: got %b want 1", bus_rdy); end
        n_vec++; if (biu_err_o !== 1'b1) begin n_err++; $display("FAIL er_err: got %b want 1", biu_err_o); end
        n_vec++; if (biu_dat_o !== 32'hB2) begin n_err++; $display("FAIL er_bdat: got %h want b2", biu_dat_o); end
        for (int k = 0; k < 8; k++) begin
            exp_w = (k < 3) ? 32'hB0 + 32'(k) : 32'hA0 + 32'(k);
            n_vec++; if (bus_rdata_o[32*k +: 32] !== exp_w) begin n_err++; $display("FAIL er_word[%0d]: got %h want %h", k, bus_rdata_o[32*k +: 32], exp_w); end
        end
        tick();
        n_vec++; if (bus_rdy !== 1'b0 || biu_err_o !== 1'b0) begin n_err++; $display("FAIL er_clear: rdy/err got %b%b want 00", bus_rdy, biu_err_o); end
    endtask

    task automatic test_retry();
        issue(1'b0, 1'b1, 1'b0, 32'h0000_4000, 4'h0);
        for (int k = 0; k < 2; k++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'hC0 + 32'(k);
            tick();
        end
        wb_ack_i = 1'b0;
        n_vec++; if (wb_adr_o !== 32'h4008) begin n_err++; $display("FAIL rt_adr2: got %h want 4008", wb_adr_o); end
        wb_rty_i = 1'b1;
        tick();
        wb_rty_i = 1'b0;
`ifdef WB_BURST_BIU_RTY_EN
        n_vec++; if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b1) begin n_err++; $display("FAIL rt_gap: cyc/stb got %b%b want 10", wb_cyc_o, wb_stb_o); end
        n_vec++; if (wb_adr_o !== 32'h4008) begin n_err++; $display("FAIL rt_gap_adr: got %h want 4008", wb_adr_o); end
        tick();
        n_vec++; if (wb_stb_o !== 1'b1) begin n_err++; $display("FAIL rt_reissue_stb: got %b want 1", wb_stb_o); end
        for (int k = 2; k < 8; k++) begin
            n_vec++; if (wb_adr_o !== 32'h4000 + 32'(4 * k)) begin n_err++; $display("FAIL rt_adr[%0d]: got %h want %h", k, wb_adr_o, 32'h4000 + 32'(4 * k)); end
            wb_ack_i = 1'b1; wb_dat_i = 32'hC0 + 32'(k);
            tick();
        end
        wb_ack_i = 1'b0;
        n_vec++; if (bus_rdy !== 1'b1 || biu_err_o !== 1'b0) begin n_err++; $display("FAIL rt_done: rdy/err got %b%b want 10", bus_rdy, biu_err_o); end
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (bus_rdata_o[32*k +: 32] !== 32'hC0 + 32'(k)) begin n_err++; $display("FAIL rt_word[%0d]: got %h want %h", k, bus_rdata_o[32*k +: 32], 32'hC0 + 32'(k)); end
        end
`else
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL rt_abort_cyc: got %b want 0", wb_cyc_o); end
        n_vec++; if (bus_rdy !== 1'b1 || biu_err_o !== 1'b1) begin n_err++; $display("FAIL rt_abort: rdy/err got %b%b want 11", bus_rdy, biu_err_o); end
        n_vec++; if (bus_rdata_o[63:32] !== 32'hC1) begin n_err++; $display("FAIL rt_word1: got %h want c1", bus_rdata_o[63:32]); end
`endif
        tick();
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL rt_rdy_clear: got %b want 0", bus_rdy); end
    endtask

    task automatic test_freeze_back_to_back();
        bus_wdata_i[31:0] = 32'h1234_5678;
        freeze = 1'b1;
        biu_cyc_i = 1'b1; biu_stb_i = 1'b1; biu_we_i = 1'b1; biu_cab_i = 1'b0;
        prp_acs = 1'b1; biu_adr_i = 32'h0000_0010; biu_sel_i = 4'hF;
        tick();
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL fz_block0: got %b want 0", wb_cyc_o); end
        tick();
        n_vec++; if (wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL fz_block1: got %b want 0", wb_cyc_o); end
        freeze = 1'b0;
        tick();
        n_vec++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin n_err++; $display("FAIL fz_accept: cyc/we got %b%b want 11", wb_cyc_o, wb_we_o); end
        n_vec++; if (wb_dat_o !== 32'h1234_5678) begin n_err++; $display("FAIL fz_dat: got %h want 12345678", wb_dat_o); end
        freeze = 1'b1; wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        n_vec++; if (bus_rdy !== 1'b1 || wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL fz_done: rdy/cyc got %b%b want 10", bus_rdy, wb_cyc_o); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if (bus_rdy !== 1'b1 || wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL fz_hold[%0d]: rdy/cyc got %b%b want 10", k, bus_rdy, wb_cyc_o); end
        end
        freeze = 1'b0;
        tick();
        n_vec++; if (bus_rdy !== 1'b0 || wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL fz_release: rdy/cyc got %b%b want 00", bus_rdy, wb_cyc_o); end
        tick();
        n_vec++; if (wb_cyc_o !== 1'b1) begin n_err++; $display("FAIL b2b_reaccept: got %b want 1", wb_cyc_o); end
        biu_cyc_i = 1'b0; biu_stb_i = 1'b0;
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        n_vec++; if (bus_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy: got %b want 1", bus_rdy); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        issue(1'b0, 1'b1, 1'b0, 32'h0000_5000, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wb_ack_i = 1'b1; wb_dat_i = 32'hD0 + 32'(k);
            tick();
        end
        wb_ack_i = 1'b0;
        n_vec++; if (wb_adr_o !== 32'h5010) begin n_err++; $display("FAIL rm_adr4: got %h want 5010", wb_adr_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_err++; $display("FAIL rm_cycstb: got %b%b want 00", wb_cyc_o, wb_stb_o); end
        n_vec++; if (wb_adr_o !== 32'd0 || wb_cti_o !== 3'd0) begin n_err++; $display("FAIL rm_adrcti: got %h/%b want 0/0", wb_adr_o, wb_cti_o); end
        n_vec++; if (bus_rdy !== 1'b0) begin n_err++; $display("FAIL rm_rdy: got %b want 0", bus_rdy); end
        n_vec++; if (bus_rdata_o !== 256'd0 || biu_dat_o !== 32'd0) begin n_err++; $display("FAIL rm_data: got %h/%h want 0", bus_rdata_o, biu_dat_o); end
        tick();
        n_vec++; if (bus_rdy !== 1'b0 || wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL rm_quiet: rdy/cyc got %b%b want 00", bus_rdy, wb_cyc_o); end
        issue(1'b0, 1'b0, 1'b1, 32'h0000_0044, 4'hF);
        n_vec++; if (wb_adr_o !== 32'h44) begin n_err++; $display("FAIL rm_new_adr: got %h want 44", wb_adr_o); end
        wb_ack_i = 1'b1; wb_dat_i = 32'h55;
        tick();
        wb_ack_i = 1'b0;
        n_vec++; if (bus_rdy !== 1'b1 || biu_dat_o !== 32'h55) begin n_err++; $display("FAIL rm_new_done: rdy/bdat got %b/%h want 1/55", bus_rdy, biu_dat_o); end
        tick();
    endtask

    // Safety net in case the run stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; freeze = 1'b0;
        biu_cyc_i = 1'b0; biu_stb_i = 1'b0; biu_we_i = 1'b0; biu_cab_i = 1'b0;
        prp_acs = 1'b0; biu_adr_i = 32'd0; biu_sel_i = 4'd0; bus_wdata_i = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'd0;
        test_reset();
        test_read_burst();
        test_write_burst();
        test_single_read();
        test_error();
        test_retry();
        test_freeze_back_to_back();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_burst_biu.md
Name: wb_burst_biu

Overview:
- Single-clock Wishbone B3 bus interface unit between the data-cache controller and the system bus.
- Converts a cache line request into an 8-beat incrementing Wishbone burst, read or write, of 256 bits.
- Converts a peripheral/uncached request into a single 32-bit classic cycle.
- Returns the filled line and a one-cycle completion strobe to the cache.

Parameters:
- BEATS, 8, words per line burst (line = 32*BEATS bits; fixed at 8 for this revision).

Ports:
- clk  in  1  system clock; all logic and the Wishbone bus are synchronous to its rising edge.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  pipeline freeze from the core; holds bus_rdy/biu_err_o and blocks acceptance of new requests.
- biu_cyc_i  in  1  request cycle from cache.
- biu_stb_i  in  1  request strobe from cache.
- biu_we_i  in  1  1=write, 0=read.
- biu_cab_i  in  1  consecutive-address (line burst) request.
- prp_acs  in  1  peripheral/uncached access; forces a single cycle.
- biu_adr_i  in  32  request byte address.
- biu_sel_i  in  4  byte enables for single cycles.
- bus_wdata_i  in  256  write line (word k = bits 32k+31:32k); single write uses word 0.
- biu_dat_o  out  32  data of the most recent read beat.
- bus_rdata_o  out  256  assembled read line.
- bus_rdy  out  1  transaction complete.
- biu_err_o  out  1  transaction terminated by wb_err_i.
- wb_ack_i  in  1  Wishbone acknowledge.
- wb_err_i  in  1  Wishbone error.
- wb_rty_i  in  1  Wishbone retry.
- wb_dat_i  in  32  Wishbone read data.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  Wishbone write enable.
- wb_adr_o  out  32  Wishbone address.
- wb_sel_o  out  4  Wishbone byte select.
- wb_dat_o  out  32  Wishbone write data.
- wb_cti_o  out  3  Wishbone cycle type identifier.
- wb_bte_o  out  2  Wishbone burst type extension.

Behaviour:
- Reset: all outputs registered and cleared to 0; state IDLE; beat counter 0.
- State machine IDLE -> BUS -> DONE -> IDLE.
- IDLE:
  - Accept a request when biu_cyc_i & biu_stb_i & ~freeze.
  - Burst when biu_cab_i & ~prp_acs; otherwise single.
  - On the next edge enter BUS with wb_cyc_o=wb_stb_o=1 and wb_we_o=biu_we_i.
- Burst address setup:
  - wb_adr_o = {biu_adr_i[31:5],5'b0}.
  - wb_sel_o=4'hF, wb_bte_o=2'b00, wb_cti_o=3'b010.
  - wb_dat_o = bus_wdata_i word 0.
- Single setup:
  - wb_adr_o = biu_adr_i; wb_sel_o=biu_sel_i.
  - wb_cti_o=3'b000, wb_bte_o=2'b00, wb_dat_o=bus_wdata_i[31:0].
- Request inputs (address, data, select) are captured at acceptance; later input changes are ignored until DONE.
- BUS, on wb_ack_i:
  - Read: bus_rdata_o word[cnt] and biu_dat_o take wb_dat_i.
  - cnt increments; wb_adr_o advances by 4; wb_dat_o becomes the next write word. The address never leaves the line because cnt is 3 bits.
  - wb_cti_o=3'b111 is driven during beat 7.
- BUS, last beat (single: first ack; burst: ack with cnt=7): cyc/stb/cti drop to 0 on that edge; go to DONE.
- Beat timing: zero-wait-state slave completes a burst in 8 BUS cycles.
- BUS, wb_err_i (priority over ack):
  - Abort immediately; cyc/stb drop; go to DONE with error flag.
  - Words already stored stay valid; remaining words keep their old values.
- BUS, wb_rty_i (no ack/err): see Optional Feature.
- DONE:
  - bus_rdy=1 (biu_err_o=1 if aborted) for one cycle.
  - If freeze=1, stay in DONE holding both until freeze=0; then return to IDLE, clearing bus_rdy and biu_err_o.
- A request held continuously is re-accepted no earlier than the cycle after returning to IDLE.
- Reset mid-transaction: next edge clears cyc/stb and returns to IDLE; no bus_rdy pulse.
- Simultaneous ack and err: err wins.
- biu_dat_o and bus_rdata_o hold their values between transactions.

Optional Feature:
- WB_BURST_BIU_RTY_EN defined: wb_rty_i with no ack/err drops wb_stb_o for one cycle.
  - The same beat (same address, same cnt) is then reissued; cyc stays high.
  - There is no retry limit.
- Undefined: wb_rty_i is treated exactly as wb_err_i (abort, biu_err_o=1).

Test Plan:
- Read burst:
  - Stimulus: biu_adr_i=0x0000_1234, cab=1, prp_acs=0, we=0; slave acks every cycle with data 0xA0+k.
  - Required: addresses 0x1220..0x123C; cti 010 x7 then 111; bus_rdata_o word k=0xA0+k; bus_rdy one cycle; biu_dat_o=0xA7.
- Write burst:
  - Stimulus: bus_wdata_i words 0x11*k, address 0x2000; slave with 1 wait state per beat.
  - Required: wb_we_o=1, wb_dat_o sequence 0x00,0x11,...,0x77, each held until ack; sel=F; bus_rdy after 8th ack.
- Peripheral single read:
  - Stimulus: prp_acs=1, addr 0x9000_0004, sel 4'b0011; ack with data 0xDEADBEEF.
  - Required: cti=000, wb_sel_o=0011; biu_dat_o=0xDEADBEEF; bus_rdy pulse.
- Error mid-burst: wb_err_i on beat 3 -> cyc drops on that edge; bus_rdy=1 and biu_err_o=1; words 0-2 updated.
- Freeze and retry:
  - Freeze held high at completion -> bus_rdy stays 1 until freeze=0, then clears.
  - With WB_BURST_BIU_RTY_EN, rty on beat 2 -> stb low one cycle, same address reissued, burst completes normally.
- Reset mid-burst: rst at beat 4 -> all outputs 0 next edge; no bus_rdy pulse; a new request then proceeds normally.
